// File: rtl/pixel_frame_stats_if.sv
// Pixel-stream / statistics bundle for pixel_frame_stats.
//   master : pixel source + stats consumer (drives frame_start, pix_in,
//            pix_valid, count_level, stats_ack; observes everything else)
//   slave  : pixel_frame_stats itself
// CNT_W / SUM_W must match the parameters of the attached pixel_frame_stats.
interface pixel_frame_stats_if #(
  parameter int CNT_W = 17,
  parameter int SUM_W = 25
) ();
  logic             frame_start;
  logic [7:0]       pix_in;
  logic             pix_valid;
  logic [7:0]       count_level;
  logic             stats_ack;
  logic [8:0]       pix_x;
  logic [8:0]       pix_y;
  logic [7:0]       min_pix;
  logic [7:0]       max_pix;
  logic [SUM_W-1:0] pix_sum;
  logic [CNT_W-1:0] above_cnt;
  logic             stats_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output frame_start, pix_in, pix_valid, count_level, stats_ack,
    input  pix_x, pix_y, min_pix, max_pix, pix_sum, above_cnt,
           stats_valid, frame_err, busy
  );

  modport slave (
    input  frame_start, pix_in, pix_valid, count_level, stats_ack,
    output pix_x, pix_y, min_pix, max_pix, pix_sum, above_cnt,
           stats_valid, frame_err, busy
  );
endinterface

// File: rtl/pixel_frame_stats.sv
// pixel_frame_stats
// Consumes the raster-ordered processed pixel stream, tracks the position of
// the next expected pixel and accumulates per-frame min, max, sum and the
// number of pixels at or above count_level. When the last pixel of the frame
// is accepted the statistics are published with stats_valid and held until
// stats_ack.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus (slave)  frame_start, pix_in, pix_valid, count_level, stats_ack in;
//                pix_x, pix_y, min_pix, max_pix, pix_sum, above_cnt,
//                stats_valid, frame_err (sticky), busy out
module pixel_frame_stats #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 320,
  parameter int CNT_W = 17,
  parameter int SUM_W = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  pixel_frame_stats_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

  state_t           state;

  // running (in-frame) accumulators
  logic [8:0]       x_q, y_q;
  logic [7:0]       run_min, run_max;
  logic [SUM_W-1:0] run_sum;
  logic [CNT_W-1:0] run_cnt;

  // published statistics
  logic [7:0]       min_q, max_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, err_q;

  // next-state view of the accumulators
  logic             start_frame, accept, last_pix;
  logic [8:0]       base_x, base_y, nxt_x, nxt_y;
  logic [7:0]       base_min, base_max, nxt_min, nxt_max;
  logic [SUM_W-1:0] base_sum, nxt_sum;
  logic [CNT_W-1:0] base_cnt, nxt_cnt;

  // A frame_start restarts the accumulators first, then any same-cycle pixel
  // is folded in on top of the cleared values (it becomes pixel (0,0)).
  // In REPORT a frame_start only counts when the ack lands in the same cycle.
  always_comb begin
    start_frame = bus.frame_start && ((state != REPORT) || bus.stats_ack);
    accept      = bus.pix_valid && (start_frame || (state == ACCUM));

    if (start_frame) begin
      base_x   = '0;
      base_y   = '0;
      base_min = '1;
      base_max = '0;
      base_sum = '0;
      base_cnt = '0;
    end else begin
      base_x   = x_q;
      base_y   = y_q;
      base_min = run_min;
      base_max = run_max;
      base_sum = run_sum;
      base_cnt = run_cnt;
    end

    nxt_x    = base_x;
    nxt_y    = base_y;
    nxt_min  = base_min;
    nxt_max  = base_max;
    nxt_sum  = base_sum;
    nxt_cnt  = base_cnt;
    last_pix = 1'b0;

    if (accept) begin
      if (bus.pix_in < base_min) nxt_min = bus.pix_in;
      if (bus.pix_in > base_max) nxt_max = bus.pix_in;
      nxt_sum = base_sum + SUM_W'(bus.pix_in);
      if (bus.pix_in >= bus.count_level) nxt_cnt = base_cnt + CNT_W'(1);

      if (base_x == X_LAST) begin
        nxt_x = '0;
        if (base_y == Y_LAST) begin
          nxt_y    = '0;
          last_pix = 1'b1;
        end else begin
          nxt_y = base_y + 9'd1;
        end
      end else begin
        nxt_x = base_x + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      run_min <= '1;
      run_max <= '0;
      run_sum <= '0;
      run_cnt <= '0;
      min_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      x_q     <= nxt_x;
      y_q     <= nxt_y;
      run_min <= nxt_min;
      run_max <= nxt_max;
      run_sum <= nxt_sum;
      run_cnt <= nxt_cnt;

      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state <= ACCUM;
            err_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (bus.frame_start) err_q <= 1'b1;
        end
        REPORT: begin
          if (bus.stats_ack) begin
            valid_q <= 1'b0;
            if (bus.frame_start) begin
              state <= ACCUM;
              err_q <= 1'b0;
            end else begin
              state <= IDLE;
              if (bus.pix_valid) err_q <= 1'b1;
            end
          end else if (bus.frame_start || bus.pix_valid) begin
            err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Publishing on the accepting edge gives stats one cycle after the
      // last pixel; it overrides the state chosen above.
      if (last_pix) begin
        state   <= REPORT;
        min_q   <= nxt_min;
        max_q   <= nxt_max;
        sum_q   <= nxt_sum;
        cnt_q   <= nxt_cnt;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.pix_x       = (state == ACCUM) ? x_q : '0;
  assign bus.pix_y       = (state == ACCUM) ? y_q : '0;
  assign bus.min_pix     = min_q;
  assign bus.max_pix     = max_q;
  assign bus.pix_sum     = sum_q;
  assign bus.above_cnt   = cnt_q;
  assign bus.stats_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state == ACCUM);

endmodule
